// File: rtl/ex_stage.sv
// ex_stage: Mipu execute stage - ALU, branch resolution, flags and EX/MEM pipeline registers.
// Define EX_CARRY_EN to make ADDC/SUBC consume cf and arithmetic ops write cf; otherwise cf is tied to 0.
`ifndef EXEC
`define EXEC  1'b1
`endif
`ifndef NOP
`define NOP   5'b00000
`define LOAD  5'b00010
`define STORE 5'b00011
`define LDIH  5'b10000
`define ADD   5'b01000
`define ADDI  5'b01001
`define ADDC  5'b10001
`define SUB   5'b01010
`define SUBI  5'b01011
`define SUBC  5'b10010
`define CMP   5'b01100
`define AND   5'b01101
`define OR    5'b01110
`define XOR   5'b01111
`define SLL   5'b00100
`define SLA   5'b00101
`define SRL   5'b00110
`define SRA   5'b00111
`define JMPR  5'b11001
`define BZ    5'b11010
`define BNZ   5'b11011
`define BN    5'b11100
`define BNN   5'b11101
`define BC    5'b11110
`define BNC   5'b11111
`endif
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] ex_ir,
  input  logic [15:0] reg_A,
  input  logic [15:0] reg_B,
  input  logic [15:0] smdr,
  output logic [15:0] ALUo,
  output logic        jump,
  output logic [15:0] mem_ir,
  output logic [15:0] reg_C,
  output logic [15:0] smdr1,
  output logic        dw,
  output logic        zf,
  output logic        nf,
  output logic        cf
);
  logic [4:0]  op;
  logic [16:0] add_r, sub_r;
  logic [15:0] sll_r, srl_r, sra_r;
  logic        zn_upd, c_upd, c_new;
  logic        run;
  assign op    = ex_ir[15:11];
  assign run   = state == `EXEC;
  // cf reads 0 in the carry-less build, so ADDC/SUBC collapse to ADD/SUB
  assign add_r = {1'b0, reg_A} + {1'b0, reg_B} + {16'd0, op == `ADDC && cf};
  assign sub_r = {1'b0, reg_A} - {1'b0, reg_B} - {16'd0, op == `SUBC && cf};
  assign sll_r = reg_A << reg_B[3:0];
  assign srl_r = reg_A >> reg_B[3:0];
  assign sra_r = $signed(reg_A) >>> reg_B[3:0];
  always_comb begin
    ALUo   = 16'h0000;
    zn_upd = 1'b0;
    c_upd  = 1'b0;
    c_new  = 1'b0;
    case (op)
      `ADD, `ADDI, `ADDC: begin ALUo = add_r[15:0]; zn_upd = 1'b1; c_upd = 1'b1; c_new = add_r[16]; end
      `LDIH:              begin ALUo = add_r[15:0]; zn_upd = 1'b1; end
      `SUB, `SUBI, `SUBC, `CMP: begin ALUo = sub_r[15:0]; zn_upd = 1'b1; c_upd = 1'b1; c_new = sub_r[16]; end
      `AND:               begin ALUo = reg_A & reg_B; zn_upd = 1'b1; end
      `OR:                begin ALUo = reg_A | reg_B; zn_upd = 1'b1; end
      `XOR:               begin ALUo = reg_A ^ reg_B; zn_upd = 1'b1; end
      `SLL:               begin ALUo = sll_r; zn_upd = 1'b1; end
      `SLA:               begin ALUo = {reg_A[15], sll_r[14:0]}; zn_upd = 1'b1; end
      `SRL:               begin ALUo = srl_r; zn_upd = 1'b1; end
      `SRA:               begin ALUo = sra_r; zn_upd = 1'b1; end
      `LOAD, `STORE, `JMPR, `BZ, `BNZ, `BN, `BNN, `BC, `BNC: ALUo = add_r[15:0];
      default:            ALUo = 16'h0000;
    endcase
  end
  assign jump = run && (op == `JMPR || (op == `BZ && zf) || (op == `BNZ && !zf) ||
                        (op == `BN && nf) || (op == `BNN && !nf) ||
                        (op == `BC && cf) || (op == `BNC && !cf));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mem_ir <= 16'h0000;
      reg_C  <= 16'h0000;
      smdr1  <= 16'h0000;
      dw     <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
    end else if (run) begin
      mem_ir <= ex_ir;
      reg_C  <= ALUo;
      smdr1  <= smdr;
      dw     <= op == `STORE;
      if (zn_upd) begin
        zf <= ALUo == 16'h0000;
        nf <= ALUo[15];
      end
    end
`ifdef EX_CARRY_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) cf <= 1'b0;
    else if (run && c_upd) cf <= c_new;
`else
  logic unused_c;
  assign unused_c = c_upd ^ c_new;
  assign cf = 1'b0;
`endif
endmodule
